// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width and
// the bit-counter sizing helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Counter only needs to reach WIDTH-1, but never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 32'd1) ? 32'($clog2(w)) : 32'd1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; master issues operands, slave
// returns the registered sum.
interface serial_adder_if #(
  parameter int unsigned WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             C_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] S_o;
  logic             C_o;

  modport master (
    output start_i, A_i, B_i, C_i,
    input  busy_o, done_o, S_o, C_o
  );

  modport slave (
    input  start_i, A_i, B_i, C_i,
    output busy_o, done_o, S_o, C_o
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell reused by the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_i,
  output logic S_o,
  output logic C_o
);
  assign S_o = A ^ B ^ C_i;
  assign C_o = (A & B) | (C_i & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, one bit per clock,
// result registered and held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             carry_out_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .C_i (carry),
    .S_o (fa_s),
    .C_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign s_nxt    = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Next-state decode; start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_nxt = ST_RUN;
          accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start_i) begin
          state_nxt = ST_RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      s_sr        <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == ST_RUN);
      done_q <= (state_nxt == ST_DONE);
      if (accept) begin
        a_sr  <= bus.A_i;
        b_sr  <= bus.B_i;
        carry <= bus.C_i;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        carry <= fa_c;
        s_sr  <= s_nxt;
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        // Counter parks at WIDTH-1 rather than wrapping.
        if (last_bit) begin
          sum_q       <= s_nxt;
          carry_out_q <= fa_c;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.S_o    = sum_q;
  assign bus.C_o    = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: WIDTH=8, 1 and 32 adders checked every cycle against a
// latency/result model, plus directed literal checks.
module tb_serial_adder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        drv_st [NI];
  logic [31:0] drv_a  [NI];
  logic [31:0] drv_b  [NI];
  logic        drv_c  [NI];
  logic        out_busy [NI];
  logic        out_done [NI];
  logic        out_c    [NI];
  logic [31:0] out_s    [NI];

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(8))  u_w8  (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
  serial_adder #(.WIDTH(1))  u_w1  (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  serial_adder #(.WIDTH(32)) u_w32 (.clk_i(clk), .rst_i(rst), .bus(if32.slave));

  assign if8.start_i  = drv_st[0];
  assign if8.A_i      = drv_a[0][7:0];
  assign if8.B_i      = drv_b[0][7:0];
  assign if8.C_i      = drv_c[0];
  assign if1.start_i  = drv_st[1];
  assign if1.A_i      = drv_a[1][0:0];
  assign if1.B_i      = drv_b[1][0:0];
  assign if1.C_i      = drv_c[1];
  assign if32.start_i = drv_st[2];
  assign if32.A_i     = drv_a[2];
  assign if32.B_i     = drv_b[2];
  assign if32.C_i     = drv_c[2];

  assign out_busy[0] = if8.busy_o;
  assign out_done[0] = if8.done_o;
  assign out_c[0]    = if8.C_o;
  assign out_s[0]    = 32'(if8.S_o);
  assign out_busy[1] = if1.busy_o;
  assign out_done[1] = if1.done_o;
  assign out_c[1]    = if1.C_o;
  assign out_s[1]    = 32'(if1.S_o);
  assign out_busy[2] = if32.busy_o;
  assign out_done[2] = if32.done_o;
  assign out_c[2]    = if32.C_o;
  assign out_s[2]    = if32.S_o;

  function automatic int unsigned wid(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic longint unsigned msk(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: an accepted request produces A+B+C after exactly WIDTH busy cycles.
  logic              armed = 1'b0;
  logic              m_busy [NI];
  logic              m_done [NI];
  longint unsigned   m_res  [NI];
  longint unsigned   m_pend [NI];
  int                m_rem  [NI];

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_res[k]  <= 64'd0;
        m_rem[k]  <= 0;
      end else if (m_busy[k]) begin
        m_rem[k]  <= m_rem[k] - 1;
        m_done[k] <= (m_rem[k] == 1);
        if (m_rem[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_res[k]  <= m_pend[k];
        end
      end else begin
        m_done[k] <= 1'b0;
        if (drv_st[k]) begin
          m_busy[k] <= 1'b1;
          m_rem[k]  <= int'(wid(k));
          m_pend[k] <= ((64'(drv_a[k]) & msk(wid(k))) + (64'(drv_b[k]) & msk(wid(k)))
                        + 64'(drv_c[k])) & msk(wid(k) + 1);
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one cycle and compare every instance against the model.
  task automatic tick();
    logic [34:0] e;
    logic [34:0] a;
    @(negedge clk);
    if (armed) begin
      for (int k = 0; k < NI; k++) begin
        e = {m_busy[k], m_done[k], 1'(m_res[k] >> wid(k)), 32'(m_res[k] & msk(wid(k)))};
        a = {out_busy[k], out_done[k], out_c[k], out_s[k]};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model_w%0d at %0t: got busy/done/C/S=%b/%b/%b/0x%0h expected %b/%b/%b/0x%0h",
                   wid(k), $time, a[34], a[33], a[32], a[31:0], e[34], e[33], e[32], e[31:0]);
        end
      end
    end
  endtask

  task automatic go(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
    drv_a[k]  = a;
    drv_b[k]  = b;
    drv_c[k]  = c;
    drv_st[k] = 1'b1;
    tick();
    drv_st[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int n);
    n = 1;
    while (out_done[k] !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
  endtask

  function automatic longint unsigned res(input int k);
    return (64'(out_c[k]) << wid(k)) | 64'(out_s[k]);
  endfunction

  initial begin
    int n;
    int dn;
    int last;
    int dn8;
    int dn32;
    longint unsigned got;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      drv_st[k] = 1'b0;
      drv_a[k]  = 32'd0;
      drv_b[k]  = 32'd0;
      drv_c[k]  = 1'b0;
    end
    tick();
    tick();
    chk("reset_state_w8", 64'({out_busy[0], out_done[0], out_c[0], out_s[0]}), 64'd0);
    rst = 1'b0;
    tick();

    go(0, 32'h00, 32'h00, 1'b0);
    wait_done(0, n);
    chk("latency_0+0", 64'(n), 64'd9);
    chk("sum_0+0", res(0), 64'h000);
    tick();

    go(0, 32'hFF, 32'h01, 1'b0);
    wait_done(0, n);
    chk("sum_ff+01", res(0), 64'h100);
    tick();

    go(0, 32'hFF, 32'hFF, 1'b1);
    wait_done(0, n);
    chk("sum_ff+ff+1", res(0), 64'h1FF);
    tick();

    // Second start while running must be ignored.
    go(0, 32'h0F, 32'h01, 1'b0);
    tick();
    tick();
    drv_a[0]  = 32'hAA;
    drv_st[0] = 1'b1;
    tick();
    drv_st[0] = 1'b0;
    dn  = 0;
    got = 64'd0;
    repeat (14) begin
      tick();
      if (out_done[0] === 1'b1) begin
        dn++;
        got = res(0);
      end
    end
    chk("ignored_start_dones", 64'(dn), 64'd1);
    chk("ignored_start_sum", got, 64'h010);

    // Reset mid-run aborts and clears the held result.
    go(0, 32'h55, 32'h22, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", 64'({out_busy[0], out_done[0], out_c[0], out_s[0]}), 64'd0);
    dn = 0;
    repeat (20) begin
      tick();
      if (out_done[0] === 1'b1) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    // Start held high: a new result every WIDTH+1 cycles.
    drv_a[0]  = 32'h12;
    drv_b[0]  = 32'h34;
    drv_c[0]  = 1'b0;
    drv_st[0] = 1'b1;
    last = -1;
    dn   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_done[0] === 1'b1) begin
        dn++;
        chk("held_sum", res(0), 64'h046);
        if (last >= 0) chk("held_interval", 64'(i - last), 64'd9);
        last = i;
      end
    end
    drv_st[0] = 1'b0;
    chk("held_done_count", 64'(dn), 64'd4);
    repeat (12) tick();

    // WIDTH=1 exhaustive: a registered full adder.
    for (int v = 0; v < 8; v++) begin
      go(1, 32'((v >> 2) & 1), 32'((v >> 1) & 1), 1'(v & 1));
      wait_done(1, n);
      chk("w1_latency", 64'(n), 64'd2);
      chk("w1_sum", res(1), 64'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)));
      if (v == 7) chk("w1_111", res(1), 64'd3);
      tick();
    end

    // Random traffic on the 8- and 32-bit adders with rare resets.
    dn8  = 0;
    dn32 = 0;
    for (int i = 0; i < 75000 && (dn8 < 1000 || dn32 < 1000); i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      for (int k = 0; k < NI; k += 2) begin
        drv_st[k] = 1'($urandom_range(0, 1));
        drv_a[k]  = $urandom;
        drv_b[k]  = $urandom;
        drv_c[k]  = 1'($urandom);
      end
      tick();
      if (out_done[0] === 1'b1) dn8++;
      if (out_done[2] === 1'b1) dn32++;
    end
    rst       = 1'b0;
    drv_st[0] = 1'b0;
    drv_st[2] = 1'b0;
    chk("rand_w8_results", 64'(dn8 >= 1000), 64'd1);
    chk("rand_w32_results", 64'(dn32 >= 1000), 64'd1);
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
